// File: rtl/cve2_trace_buffer.sv
// cve2_trace_buffer: retirement-trace capture FIFO fed from the RVFI port.
// Each enabled retirement is packed into a compact record and queued for a
// valid/ready trace sink. The core is never stalled: on overflow the record
// is dropped and the loss count rides along with the next accepted record.
// Optional feature: define CVE2_TRACE_TIMESTAMP_EN to add a free-running
// 32-bit cycle counter whose value is stored with each record.
module cve2_trace_buffer #(
  parameter int Depth        = 8,
  parameter int DropCntWidth = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      flush_i,
  input  logic                      rvfi_valid_i,
  input  logic [31:0]               rvfi_pc_rdata_i,
  input  logic [31:0]               rvfi_insn_i,
  input  logic [4:0]                rvfi_rd_addr_i,
  input  logic [31:0]               rvfi_rd_wdata_i,
  input  logic                      rvfi_trap_i,
  input  logic                      rvfi_intr_i,
  input  logic [1:0]                rvfi_mode_i,
  output logic                      trace_valid_o,
  input  logic                      trace_ready_i,
  output logic [31:0]               trace_pc_o,
  output logic [31:0]               trace_insn_o,
  output logic [31:0]               trace_rd_wdata_o,
  output logic [4:0]                trace_rd_addr_o,
  output logic [3:0]                trace_flags_o,
  output logic [DropCntWidth-1:0]   trace_dropped_o,
  output logic [31:0]               trace_ts_o,
  output logic [$clog2(Depth):0]    trace_level_o
);

  localparam int PtrW = $clog2(Depth);

  typedef struct packed {
    logic [31:0]             pc;
    logic [31:0]             insn;
    logic [31:0]             wdata;
    logic [4:0]              rd;
    logic [3:0]              flags;
    logic [DropCntWidth-1:0] dropped;
`ifdef CVE2_TRACE_TIMESTAMP_EN
    logic [31:0]             ts;
`endif
  } entry_t;

  entry_t                  r_mem [Depth];
  logic [PtrW-1:0]         r_rd_ptr;
  logic [PtrW-1:0]         r_wr_ptr;
  logic [PtrW:0]           r_level;
  logic [DropCntWidth-1:0] r_drop_cnt;

  logic   w_full, w_empty, w_pop, w_cap, w_push, w_drop;
  entry_t w_wr_entry;
  entry_t w_head;

  assign w_full  = (r_level == (PtrW+1)'(Depth));
  assign w_empty = (r_level == '0);
  assign w_pop   = ~w_empty & trace_ready_i;
  // A retirement the buffer is responsible for; flush suppresses capture.
  assign w_cap   = rvfi_valid_i & enable_i & ~flush_i;
  // Full is still writable when the head leaves in the same cycle.
  assign w_push  = w_cap & (~w_full | w_pop);
  assign w_drop  = w_cap & w_full & ~w_pop;

`ifdef CVE2_TRACE_TIMESTAMP_EN
  logic [31:0] r_ts;

  // Free-running cycle counter; deliberately unaffected by flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ts <= '0;
    else         r_ts <= r_ts + 32'd1;
  end
`endif

  // Assemble the record written on push, including the pending loss count.
  always_comb begin
    w_wr_entry         = '0;
    w_wr_entry.pc      = rvfi_pc_rdata_i;
    w_wr_entry.insn    = rvfi_insn_i;
    w_wr_entry.wdata   = rvfi_rd_wdata_i;
    w_wr_entry.rd      = rvfi_rd_addr_i;
    w_wr_entry.flags   = {rvfi_mode_i, rvfi_intr_i, rvfi_trap_i};
    w_wr_entry.dropped = r_drop_cnt;
`ifdef CVE2_TRACE_TIMESTAMP_EN
    w_wr_entry.ts      = r_ts;
`endif
  end

  // Storage array; reset to zero so the outputs never show X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // Pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (PtrW+1)'(1);
        2'b01:   r_level <= r_level - (PtrW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Saturating loss counter; handed off and cleared by the next push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drop_cnt <= '0;
    end else if (flush_i || w_push) begin
      r_drop_cnt <= '0;
    end else if (w_drop && !(&r_drop_cnt)) begin
      r_drop_cnt <= r_drop_cnt + DropCntWidth'(1);
    end
  end

  assign w_head           = r_mem[r_rd_ptr];
  assign trace_valid_o    = ~w_empty;
  assign trace_level_o    = r_level;
  assign trace_pc_o       = w_head.pc;
  assign trace_insn_o     = w_head.insn;
  assign trace_rd_wdata_o = w_head.wdata;
  assign trace_rd_addr_o  = w_head.rd;
  assign trace_flags_o    = w_head.flags;
  assign trace_dropped_o  = w_head.dropped;
`ifdef CVE2_TRACE_TIMESTAMP_EN
  assign trace_ts_o       = w_head.ts;
`else
  assign trace_ts_o       = 32'd0;
`endif

endmodule

// File: doc/cve2_trace_buffer.md
# cve2_trace_buffer

Retirement-trace capture buffer that sits directly downstream of the core's RVFI port in tracing builds. Each cycle `rvfi_valid` is high, it packs a compact record (PC, instruction, destination write, flags) into a FIFO and presents it on a valid/ready stream to a trace sink (DPI logger, debug-bus reader or off-chip port). The core cannot be stalled by the RVFI port, so on overflow the buffer drops records and reports the loss count with the next record it accepts.

## Interface

- `Depth`, 8: number of FIFO entries; a power of two, at least 2.
- `DropCntWidth`, 16: width of the saturating dropped-record counter.

- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `enable_i`  in  1  capture enable; when low, retirements are ignored and not counted as drops.
- `flush_i`  in  1  synchronous clear of FIFO contents and drop counter.
- `rvfi_valid_i`  in  1  instruction retired this cycle.
- `rvfi_pc_rdata_i`  in  32  PC of the retired instruction.
- `rvfi_insn_i`  in  32  instruction word.
- `rvfi_rd_addr_i`  in  5  destination register; 0 means no write.
- `rvfi_rd_wdata_i`  in  32  destination write data.
- `rvfi_trap_i`  in  1  retirement trapped.
- `rvfi_intr_i`  in  1  first instruction of a handler.
- `rvfi_mode_i`  in  2  privilege mode.
- `trace_valid_o`  out  1  record available.
- `trace_ready_i`  in  1  sink accepts the record.
- `trace_pc_o`, `trace_insn_o`, `trace_rd_wdata_o`  out  32 each  record fields.
- `trace_rd_addr_o`  out  5  record field.
- `trace_flags_o`  out  4  {mode[1:0], intr, trap}.
- `trace_dropped_o`  out  DropCntWidth  records lost immediately before this one.
- `trace_ts_o`  out  32  cycle timestamp of the retirement.
- `trace_level_o`  out  $clog2(Depth)+1  current occupancy.

## Operation

- Storage: Depth-entry register FIFO with a read pointer, a write pointer (log2 Depth bits, natural wrap) and an occupancy counter (0..Depth). `full` is defined as occupancy == Depth; `empty` as occupancy == 0.
- pop = `trace_valid_o` & `trace_ready_i`.
- push = `rvfi_valid_i` & `enable_i` & !`flush_i` & (!full | pop). Push while full is allowed only in a cycle with a simultaneous pop, and the occupancy then stays at Depth.
- Drop: `rvfi_valid_i` & `enable_i` & !`flush_i` & full & !pop. The drop counter increments and saturates at all-ones.
- On push, the entry stores the RVFI fields, the current drop-counter value and the timestamp. The drop counter clears in the same cycle. If push and drop could coincide, push wins, because the two are mutually exclusive by definition.
- Occupancy: next = occupancy + push − pop.
- `flush_i` has priority over push and pop. It clears the pointers, occupancy and drop counter, and `trace_valid_o` falls the next cycle.
- Outputs: `trace_valid_o` = !empty. Record fields = entry[rd_ptr]. The data is held stable while valid & !ready. Field values when empty are don't-care, but no X is permitted after reset.

## Timing

- Reset values: `trace_valid_o`=0, `trace_level_o`=0, all record outputs 0. The pointers, drop counter and timestamp are 0, and the storage array is reset to 0.
- Latency: a retirement at edge N is visible with `trace_valid_o`=1 in cycle N+1 when the FIFO was empty.
- Throughput: 1 record/cycle in and out.
- Handshake: `trace_valid_o` never drops without a pop or a flush. The sink may hold `trace_ready_i` high continuously.
- Asynchronous reset mid-stream discards all contents. There is no partial record.

## Configuration

- `CVE2_TRACE_TIMESTAMP_EN` defined: a free-running 32-bit cycle counter is instantiated. It resets to 0, increments every cycle, wraps 0xFFFFFFFF→0, and is not affected by `flush_i`. The counter value in the push cycle is stored per entry and presented on `trace_ts_o`.
- `CVE2_TRACE_TIMESTAMP_EN` not defined: no counter and no per-entry timestamp storage; `trace_ts_o` is tied to 0.

## Test plan

- Single record: reset, enable=1, ready=0, one retirement with pc=0x80000000, insn=0x00500093, rd=1, wdata=5 -> next cycle valid=1, fields match, level=1, dropped=0. Then ready=1 -> valid=0 the following cycle.
- Fill and overflow, Depth=8, ready=0: 11 back-to-back retirements -> level=8, 3 dropped. Drain one record, then retire one more -> the 9th stored record shows dropped=3, and the counter returns to 0.
- Full with simultaneous push+pop: full FIFO, ready=1 and a retirement in the same cycle -> no drop, level stays 8, and ordering is preserved.
- Saturation, DropCntWidth=4, full, ready=0: 20 retirements -> next accepted record shows dropped=15.
- Flush and disable: flush_i with level=5 -> valid=0 and level=0 next cycle. enable_i=0 with 3 retirements -> level=0 and the next accepted record shows dropped=0.
- Timestamp, macro defined: retirements at cycles 10 and 13 after reset -> ts=10 and 13. Macro undefined -> ts=0.
